// File: rtl/pvt_probe_scanner_if.sv
// Probe-scanner signal bundle: CSR-side configuration/results plus the ADC and analog-mux front end.
// The master modport is the scanner's view; slave is the surrounding CSR block and front end.
interface pvt_probe_scanner_if #(
    parameter int unsigned NUM_PROBES = 8,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned SETTLE_W   = 10
);
    localparam int unsigned ID_W = $clog2(NUM_PROBES);

    logic                  i_enable;
    logic [NUM_PROBES-1:0] i_probe_mask;
    logic [SETTLE_W-1:0]   i_settle_cycles;
    logic [DATA_W-1:0]     i_thresh_hi;
    logic [NUM_PROBES-1:0] i_alarm_clr;
    logic                  i_adc_done;
    logic [DATA_W-1:0]     i_adc_data;
    logic [ID_W-1:0]       o_probe_sel;
    logic                  o_bias_en;
    logic                  o_adc_start;
    logic                  o_result_valid;
    logic [ID_W-1:0]       o_result_id;
    logic [DATA_W-1:0]     o_result_data;
    logic [NUM_PROBES-1:0] o_alarm;
    logic                  o_timeout_err;
    logic                  o_busy;

    modport master (
        input  i_enable, i_probe_mask, i_settle_cycles, i_thresh_hi, i_alarm_clr,
               i_adc_done, i_adc_data,
        output o_probe_sel, o_bias_en, o_adc_start, o_result_valid, o_result_id,
               o_result_data, o_alarm, o_timeout_err, o_busy
    );

    modport slave (
        output i_enable, i_probe_mask, i_settle_cycles, i_thresh_hi, i_alarm_clr,
               i_adc_done, i_adc_data,
        input  o_probe_sel, o_bias_en, o_adc_start, o_result_valid, o_result_id,
               o_result_data, o_alarm, o_timeout_err, o_busy
    );
endinterface

// File: rtl/pvt_probe_scanner.sv
// Round-robin remote thermal probe scanner: select, bias, settle, average AVG_SAMPLES ADC
// conversions per probe, report the mean and raise sticky over-threshold alarms.
module pvt_probe_scanner #(
    parameter int unsigned NUM_PROBES     = 8,
    parameter int unsigned DATA_W         = 12,
    parameter int unsigned AVG_SAMPLES    = 4,
    parameter int unsigned SETTLE_W       = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    pvt_probe_scanner_if.master bus
);
    localparam int unsigned ID_W    = $clog2(NUM_PROBES);
    localparam int unsigned AVG_LOG = $clog2(AVG_SAMPLES);
    localparam int unsigned ACC_W   = DATA_W + AVG_LOG;
    localparam int unsigned SMP_W   = (AVG_LOG > 0) ? AVG_LOG : 1;
    localparam int unsigned TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, SELECT, SETTLE, CONVERT, REPORT} state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       probe_sel_q, probe_sel_d;
    logic [ID_W-1:0]       last_q, last_d;
    logic [ID_W-1:0]       result_id_q, result_id_d;
    logic [DATA_W-1:0]     result_data_q, result_data_d;
    logic                  bias_en_q, bias_en_d;
    logic                  adc_start_q, adc_start_d;
    logic                  result_valid_q, result_valid_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  busy_q, busy_d;
    logic [NUM_PROBES-1:0] alarm_q, alarm_d;
    logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [SMP_W-1:0]      smp_cnt_q, smp_cnt_d;
    logic [ACC_W-1:0]      acc_q, acc_d;

    logic [ACC_W-1:0]      acc_sum;
    logic [ID_W-1:0]       next_idx;
    logic [ID_W:0]         cand;
    logic [NUM_PROBES-1:0] alarm_set;

    // Walk offsets from farthest to nearest so the nearest enabled probe after last_q wins.
    always_comb begin
        next_idx = last_q;
        cand     = '0;
        for (int unsigned k = NUM_PROBES; k >= 1; k--) begin
            cand = {1'b0, last_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_PROBES)) begin
                cand = cand - (ID_W+1)'(NUM_PROBES);
            end
            if (bus.i_probe_mask[cand[ID_W-1:0]]) begin
                next_idx = cand[ID_W-1:0];
            end
        end
    end

    assign acc_sum = acc_q + ACC_W'(bus.i_adc_data);

    always_comb begin
        state_d        = state_q;
        probe_sel_d    = probe_sel_q;
        last_d         = last_q;
        result_id_d    = result_id_q;
        result_data_d  = result_data_q;
        adc_start_d    = 1'b0;
        result_valid_d = 1'b0;
        timeout_err_d  = 1'b0;
        settle_cnt_d   = settle_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        smp_cnt_d      = smp_cnt_q;
        acc_d          = acc_q;
        alarm_set      = '0;

        case (state_q)
            IDLE: begin
                if (bus.i_enable && (|bus.i_probe_mask)) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (bus.i_probe_mask == '0) begin
                    state_d = IDLE;
                end else begin
                    probe_sel_d  = next_idx;
                    last_d       = next_idx;
                    settle_cnt_d = (bus.i_settle_cycles == '0) ? SETTLE_W'(1) : bus.i_settle_cycles;
                    acc_d        = '0;
                    smp_cnt_d    = '0;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_q <= SETTLE_W'(1)) begin
                    state_d     = CONVERT;
                    adc_start_d = 1'b1;
                    tmo_cnt_d   = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            CONVERT: begin
                // A done pulse in the expiry cycle still counts; the start cycle itself is blind.
                if (!adc_start_q && bus.i_adc_done) begin
                    acc_d     = acc_sum;
                    tmo_cnt_d = '0;
                    if (smp_cnt_q == SMP_W'(AVG_SAMPLES - 1)) begin
                        state_d        = REPORT;
                        result_valid_d = 1'b1;
                        result_id_d    = probe_sel_q;
                        result_data_d  = acc_sum[ACC_W-1:AVG_LOG];
                    end else begin
                        smp_cnt_d   = smp_cnt_q + 1'b1;
                        adc_start_d = 1'b1;
                    end
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = bus.i_enable ? SELECT : IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            REPORT: begin
                if (result_data_q >= bus.i_thresh_hi) begin
                    alarm_set[result_id_q] = 1'b1;
                end
                state_d = bus.i_enable ? SELECT : IDLE;
            end
            default: state_d = IDLE;
        endcase

        alarm_d   = (alarm_q & ~bus.i_alarm_clr) | alarm_set;
        bias_en_d = (state_d != IDLE);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            probe_sel_q    <= '0;
            last_q         <= ID_W'(NUM_PROBES - 1);
            result_id_q    <= '0;
            result_data_q  <= '0;
            bias_en_q      <= 1'b0;
            adc_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            busy_q         <= 1'b0;
            alarm_q        <= '0;
            settle_cnt_q   <= '0;
            tmo_cnt_q      <= '0;
            smp_cnt_q      <= '0;
            acc_q          <= '0;
        end else begin
            state_q        <= state_d;
            probe_sel_q    <= probe_sel_d;
            last_q         <= last_d;
            result_id_q    <= result_id_d;
            result_data_q  <= result_data_d;
            bias_en_q      <= bias_en_d;
            adc_start_q    <= adc_start_d;
            result_valid_q <= result_valid_d;
            timeout_err_q  <= timeout_err_d;
            busy_q         <= busy_d;
            alarm_q        <= alarm_d;
            settle_cnt_q   <= settle_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            smp_cnt_q      <= smp_cnt_d;
            acc_q          <= acc_d;
        end
    end

    assign bus.o_probe_sel    = probe_sel_q;
    assign bus.o_bias_en      = bias_en_q;
    assign bus.o_adc_start    = adc_start_q;
    assign bus.o_result_valid = result_valid_q;
    assign bus.o_result_id    = result_id_q;
    assign bus.o_result_data  = result_data_q;
    assign bus.o_alarm        = alarm_q;
    assign bus.o_timeout_err  = timeout_err_q;
    assign bus.o_busy         = busy_q;
endmodule

// File: tb/tb_pvt_probe_scanner.sv
// Directed bench for pvt_probe_scanner: a table of per-probe transactions scanned back to back,
// then hand sequences for timeout, enable drop, mask clear and mid-conversion reset.
module tb_pvt_probe_scanner;
    localparam int unsigned NP   = 8;
    localparam int unsigned DW   = 12;
    localparam int unsigned SW   = 10;
    localparam int unsigned AVG  = 4;
    localparam int unsigned TMO  = 1023;
    localparam int unsigned ID_W = $clog2(NP);

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    pvt_probe_scanner_if #(.NUM_PROBES(NP), .DATA_W(DW), .SETTLE_W(SW)) bus ();

    pvt_probe_scanner #(
        .NUM_PROBES    (NP),
        .DATA_W        (DW),
        .AVG_SAMPLES   (AVG),
        .SETTLE_W      (SW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NP-1:0]         mask;
        logic [SW-1:0]         settle;
        logic [DW-1:0]         thr;
        logic [3:0][DW-1:0]    smp;
        int                    lat;
        int                    gap;
        logic [ID_W-1:0]       id;
        logic [DW-1:0]         data;
        logic [NP-1:0]         clr;
        logic [NP-1:0]         alarm;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input logic [NP-1:0] mask, input int settle, input int thr,
                                input int s0, input int s1, input int s2, input int s3,
                                input int lat, input int gap, input int id, input int data,
                                input logic [NP-1:0] clr, input logic [NP-1:0] alarm);
        vec_t v;
        v.mask   = mask;
        v.settle = SW'(settle);
        v.thr    = DW'(thr);
        v.smp    = {DW'(s3), DW'(s2), DW'(s1), DW'(s0)};
        v.lat    = lat;
        v.gap    = gap;
        v.id     = ID_W'(id);
        v.data   = DW'(data);
        v.clr    = clr;
        v.alarm  = alarm;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns the number of negedges until o_adc_start is seen (0 if already high).
    task automatic wait_start(output int n);
        n = 0;
        while (!bus.o_adc_start && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("adc_start_seen", int'(bus.o_adc_start), 1);
    endtask

    // Entered on a SELECT-cycle negedge; leaves on the negedge after REPORT.
    task automatic run_probe(input logic [3:0][DW-1:0] smp, input int lat, input int gap,
                             input int drop_at, input logic [ID_W-1:0] id,
                             input logic [DW-1:0] data, input logic [NP-1:0] clr);
        int n;
        for (int s = 0; s < int'(AVG); s++) begin
            wait_start(n);
            if (s == 0) begin
                check("settle_gap", n, gap);
                check("probe_sel", int'(bus.o_probe_sel), int'(id));
            end else begin
                check("no_resettle", n, 0);
            end
            if (s == drop_at) bus.i_enable = 1'b0;
            repeat (lat) @(negedge clk);
            check("no_early_valid", int'(bus.o_result_valid), 0);
            bus.i_adc_done = 1'b1;
            bus.i_adc_data = smp[s];
            @(negedge clk);
            bus.i_adc_done = 1'b0;
            bus.i_adc_data = '0;
        end
        check("result_valid", int'(bus.o_result_valid), 1);
        check("result_id", int'(bus.o_result_id), int'(id));
        check("result_data", int'(bus.o_result_data), int'(data));
        check("bias_in_report", int'(bus.o_bias_en), 1);
        check("busy_in_report", int'(bus.o_busy), 1);
        bus.i_alarm_clr = clr;
        @(negedge clk);
        bus.i_alarm_clr = '0;
        check("valid_one_cycle", int'(bus.o_result_valid), 0);
    endtask

    task automatic check_all_zero();
        check("rst_probe_sel", int'(bus.o_probe_sel), 0);
        check("rst_bias_en", int'(bus.o_bias_en), 0);
        check("rst_adc_start", int'(bus.o_adc_start), 0);
        check("rst_result_valid", int'(bus.o_result_valid), 0);
        check("rst_result_id", int'(bus.o_result_id), 0);
        check("rst_result_data", int'(bus.o_result_data), 0);
        check("rst_alarm", int'(bus.o_alarm), 0);
        check("rst_timeout_err", int'(bus.o_timeout_err), 0);
        check("rst_busy", int'(bus.o_busy), 0);
    endtask

    initial begin
        int n;
        logic saw_valid;
        n_cmp = 0;
        n_err = 0;

        //            mask      set thr    s0    s1    s2    s3  lat gap id data  clr       alarm
        vecs[0] = mk(8'hA5,     3, 12'hFFF, 100,  102,  104,  106, 1, 4, 0, 103, 8'h00, 8'h00);
        vecs[1] = mk(8'hA5,     3, 12'hFFF, 100,  102,  104,  106, 2, 4, 2, 103, 8'h00, 8'h00);
        vecs[2] = mk(8'hA5,     3, 12'hFFF, 100,  102,  104,  106, 3, 4, 5, 103, 8'h00, 8'h00);
        vecs[3] = mk(8'hA5,     3, 12'hFFF, 100,  102,  104,  106, 1, 4, 7, 103, 8'h00, 8'h00);
        vecs[4] = mk(8'hA5,     3, 12'hFFF, 100,  102,  104,  106, 1, 4, 0, 103, 8'h00, 8'h00);
        vecs[5] = mk(8'hA5,     3, 12'hFFE, 4095, 4095, 4095, 4094, 2, 4, 2, 4094, 8'h00, 8'h04);
        vecs[6] = mk(8'hA5,     0, 12'hFFE, 4095, 4095, 4095, 4094, 1, 2, 5, 4094, 8'h20, 8'h24);
        vecs[7] = mk(8'h10,     5, 12'hFFF, 0,    1,    2,    3,    3, 6, 4, 1,    8'h04, 8'h20);
        vecs[8] = mk(8'h10,     2, 12'h001, 1,    1,    1,    1,    1, 3, 4, 1,    8'h00, 8'h30);
        vecs[9] = mk(8'h10,     1, 12'h002, 2,    2,    2,    1,    2, 2, 4, 1,    8'h30, 8'h00);

        rst_n               = 1'b0;
        bus.i_enable        = 1'b0;
        bus.i_probe_mask    = '0;
        bus.i_settle_cycles = '0;
        bus.i_thresh_hi     = '0;
        bus.i_alarm_clr     = '0;
        bus.i_adc_done      = 1'b0;
        bus.i_adc_data      = '0;
        repeat (3) @(negedge clk);
        check_all_zero();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", int'(bus.o_busy), 0);

        // Back-to-back table scan; each record's config lands in its SELECT cycle.
        bus.i_probe_mask = vecs[0].mask;
        bus.i_enable     = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            bus.i_probe_mask    = vecs[i].mask;
            bus.i_settle_cycles = vecs[i].settle;
            bus.i_thresh_hi     = vecs[i].thr;
            run_probe(vecs[i].smp, vecs[i].lat, vecs[i].gap, -1, vecs[i].id, vecs[i].data,
                      vecs[i].clr);
            check($sformatf("alarm_vec%0d", i), int'(bus.o_alarm), int'(vecs[i].alarm));
        end

        // Timeout on probe 5, then probe 7 with enable dropped during its second conversion.
        bus.i_probe_mask    = 8'hA5;
        bus.i_settle_cycles = SW'(1);
        bus.i_thresh_hi     = 12'hFFF;
        wait_start(n);
        check("tmo_gap", n, 2);
        check("tmo_probe_sel", int'(bus.o_probe_sel), 5);
        n = 0;
        saw_valid = 1'b0;
        while (!bus.o_timeout_err && n < 1100) begin
            @(negedge clk);
            n++;
            if (bus.o_result_valid) saw_valid = 1'b1;
        end
        check("timeout_latency", n, int'(TMO));
        check("timeout_no_result", int'(saw_valid), 0);
        check("timeout_no_alarm", int'(bus.o_alarm), 0);
        check("timeout_busy", int'(bus.o_busy), 1);
        run_probe({DW'(106), DW'(104), DW'(102), DW'(100)}, 1, 2, 1, ID_W'(7), DW'(103), '0);
        check("drop_bias_low", int'(bus.o_bias_en), 0);
        check("drop_busy_low", int'(bus.o_busy), 0);
        repeat (3) @(negedge clk);
        check("drop_stays_idle", int'(bus.o_busy), 0);

        // Mask cleared while running: the next SELECT falls back to IDLE.
        bus.i_probe_mask = 8'h01;
        bus.i_enable     = 1'b1;
        @(negedge clk);
        run_probe({DW'(8), DW'(8), DW'(8), DW'(8)}, 2, 2, -1, ID_W'(0), DW'(8), '0);
        bus.i_probe_mask = '0;
        check("mask0_select_busy", int'(bus.o_busy), 1);
        @(negedge clk);
        check("mask0_idle_busy", int'(bus.o_busy), 0);
        check("mask0_idle_bias", int'(bus.o_bias_en), 0);

        // Reset during CONVERT of probe 5; scan restarts from probe 2.
        bus.i_probe_mask = 8'h24;
        bus.i_thresh_hi  = 12'h010;
        @(negedge clk);
        run_probe({DW'(106), DW'(104), DW'(102), DW'(100)}, 1, 2, -1, ID_W'(2), DW'(103), '0);
        check("pre_reset_alarm", int'(bus.o_alarm), 8'h04);
        wait_start(n);
        check("pre_reset_sel", int'(bus.o_probe_sel), 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_probe({DW'(20), DW'(20), DW'(20), DW'(20)}, 1, 2, -1, ID_W'(2), DW'(20), '0);
        bus.i_enable = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pvt_probe_scanner.md
# pvt_probe_scanner

Digital sequencer on the PVT monitor hub side of the remote thermal probes: it scans up to NUM_PROBES remote probes round-robin. For each probe it selects the probe on the analog mux, enables probe bias, waits a programmable settle time, and runs AVG_SAMPLES ADC conversions through a start/done handshake. It reports the averaged reading per probe and raises sticky per-probe over-temperature alarms. It sits between the CSR block (configuration, results, alarms) and the PVT ADC/analog mux front end that connects to the probe pads.

## Interface
- NUM_PROBES, 8: number of remote probes, 2..16
- DATA_W, 12: ADC code width
- AVG_SAMPLES, 4: conversions per probe, power of two, 1..16
- SETTLE_W, 10: settle counter width
- TIMEOUT_CYCLES, 1023: maximum cycles from o_adc_start to i_adc_done before the probe is abandoned
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  scan enable
- i_probe_mask  in  NUM_PROBES  1 = probe included in scan
- i_settle_cycles  in  SETTLE_W  settle time after selection
- i_thresh_hi  in  DATA_W  alarm threshold, unsigned
- i_alarm_clr  in  NUM_PROBES  write-1-to-clear for o_alarm
- i_adc_done  in  1  one-cycle conversion-complete pulse
- i_adc_data  in  DATA_W  conversion result, valid with i_adc_done
- o_probe_sel  out  $clog2(NUM_PROBES)  analog mux select
- o_bias_en  out  1  probe bias current enable
- o_adc_start  out  1  one-cycle conversion request
- o_result_valid  out  1  one-cycle result strobe
- o_result_id  out  $clog2(NUM_PROBES)  probe index of the result
- o_result_data  out  DATA_W  averaged reading
- o_alarm  out  NUM_PROBES  sticky over-threshold flags
- o_timeout_err  out  1  one-cycle pulse when a conversion times out
- o_busy  out  1  FSM not in IDLE

## Operation
- States: IDLE, SELECT, SETTLE, CONVERT, REPORT.
- IDLE -> SELECT when i_enable=1 and i_probe_mask!=0.
- SELECT (one cycle):
  - Picks the lowest enabled index strictly after the last scanned index, wrapping at NUM_PROBES-1.
  - Registers that index on o_probe_sel and sets o_bias_en.
  - Latches i_settle_cycles.
  - If the mask is 0 at this point, goes to IDLE instead.
- SETTLE: lasts max(1, latched value) cycles, then goes to CONVERT.
- CONVERT:
  - o_adc_start pulses in the first cycle of each conversion.
  - i_adc_done is ignored in the cycle o_adc_start is high.
  - On i_adc_done, i_adc_data is added to an accumulator of DATA_W+log2(AVG_SAMPLES) bits, which is cleared in SELECT.
  - If fewer than AVG_SAMPLES samples have been taken, the next o_adc_start issues in the following cycle, with no re-settle.
  - After the last sample, goes to REPORT.
- REPORT (one cycle):
  - o_result_valid=1, o_result_id=o_probe_sel, o_result_data = accumulator >> log2(AVG_SAMPLES), truncating.
  - Sets o_alarm[id] if o_result_data >= i_thresh_hi.
  - Then goes to SELECT if i_enable=1, else to IDLE.
- Timeout:
  - A per-conversion counter starts at o_adc_start.
  - If i_adc_done has not arrived when the counter reaches TIMEOUT_CYCLES, o_timeout_err pulses and the probe is abandoned: no result, no alarm update, accumulated samples discarded.
  - Next state is SELECT if i_enable=1, else IDLE.
  - The abandoned probe still counts as last scanned.
- i_enable deassert is honoured only at probe boundaries (REPORT or timeout). The current probe always completes.
- Mask and threshold changes take effect at the next SELECT and REPORT respectively.
- o_bias_en is high in SELECT, SETTLE, CONVERT and REPORT, and low in IDLE.

## Timing
- Reset values: all outputs 0. The internal last-index register resets to NUM_PROBES-1, so the first probe scanned after reset is the lowest enabled index. The FSM resets to IDLE. Reset mid-scan aborts immediately with no result.
- All outputs are registered.
- Latency from i_enable to the first o_adc_start: 1 (SELECT) + max(1,settle) cycles after the IDLE exit cycle.
- Per probe: 1 + max(1,settle) + sum over samples of (1 + ADC latency) + 1 cycles.
- o_result_valid follows the final i_adc_done by exactly one cycle.
- Alarm set and i_alarm_clr on the same bit in the same cycle: set wins. i_alarm_clr takes effect the cycle after assertion.
- i_adc_done and timeout expiry in the same cycle: done wins, no error.
- i_adc_done outside CONVERT is ignored.

## Test plan
- Round-robin scan: mask=8'b1010_0101, settle=3, AVG=4, ADC returns 100, 102, 104, 106. Required: results in id order 0,2,5,7,0,…, each with o_result_data=103, and 3 SETTLE cycles before every first o_adc_start.
- Truncation and alarm: samples 4095, 4095, 4095, 4094 with thresh=4094. Required: data=4094 (16379>>2) and o_alarm[id] set. Then pulse i_alarm_clr[id] in the same cycle as a new set on that bit. Required: the bit stays 1.
- Timeout: ADC never answers. Required: o_timeout_err exactly TIMEOUT_CYCLES cycles after o_adc_start, no o_result_valid, and the scan moves to the next enabled probe.
- Enable drop mid-probe: deassert i_enable during the second conversion. Required: the probe completes and reports, then the FSM goes to IDLE, with o_bias_en and o_busy falling the cycle after REPORT.
- Edge cases:
  - settle=0 behaves as 1 cycle.
  - Single-probe mask wraps onto the same probe.
  - Mask cleared while running: IDLE at the next SELECT.
  - Async reset asserted during CONVERT: all outputs 0 immediately, and after reset release the scan restarts from the lowest enabled probe.
